// File: rtl/log_move_ctrl_pkg.sv
// Shared types and default geometry for the river-log motion sequencer.
package log_pkg;

    localparam int NUM_LOGS = 2;
    localparam int SCREEN_W = 640;
    localparam int OBJ_W    = 20;
    localparam int LANE_Y0  = 100;
    localparam int LANE_H   = 40;

    typedef logic [10:0] coord_t;
    typedef logic [3:0]  speed_t;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} log_state_t;

    // Index width that stays legal for a single-log build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/log_move_ctrl_if.sv
// Frame/config inputs and per-log position outputs of the log sequencer.
interface log_move_ctrl_if
    import log_pkg::*;
#(
    parameter int NUM_LOGS = log_pkg::NUM_LOGS
);
    localparam int IDX_W = idx_width(NUM_LOGS);

    logic             startOfFrame;
    logic             pause;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    speed_t           cfg_speed;
    logic             cfg_dir;
    coord_t           ObjectStartX [NUM_LOGS-1:0];
    coord_t           ObjectStartY [NUM_LOGS-1:0];
    logic             busy;
    logic             update_done;

    modport master (
        output startOfFrame, pause, cfg_we, cfg_idx, cfg_speed, cfg_dir,
        input  ObjectStartX, ObjectStartY, busy, update_done
    );

    modport slave (
        input  startOfFrame, pause, cfg_we, cfg_idx, cfg_speed, cfg_dir,
        output ObjectStartX, ObjectStartY, busy, update_done
    );

endinterface

// File: rtl/log_pos_step.sv
// One log position step: move x by s pixels left or right, wrapping modulo SCREEN_W.
module log_pos_step
    import log_pkg::*;
#(
    parameter int SCREEN_W = log_pkg::SCREEN_W
) (
    input  coord_t x,
    input  speed_t s,
    input  logic   dir,
    output coord_t nx
);
    localparam logic [11:0] WIDTH = 12'(SCREEN_W);

    logic [11:0] wide_x;
    logic [11:0] wide_s;
    logic [11:0] sum;
    logic [11:0] result;

    always_comb begin
        wide_x = {1'b0, x};
        wide_s = {8'b0, s};
        sum    = wide_x + wide_s;
        if (dir) begin
            result = (sum >= WIDTH) ? sum - WIDTH : sum;
        end else begin
            result = (wide_x < wide_s) ? wide_x + WIDTH - wide_s : wide_x - wide_s;
        end
        nx = coord_t'(result);
    end

endmodule

// File: rtl/log_move_ctrl.sv
// Per-frame sweep that steps each log's X once, one log per clock, with run-time speed/dir config.
module log_move_ctrl
    import log_pkg::*;
#(
    parameter int NUM_LOGS  = log_pkg::NUM_LOGS,
    parameter int SCREEN_W  = log_pkg::SCREEN_W,
    parameter int FRAME_DIV = 1,
    parameter int LANE_Y0   = log_pkg::LANE_Y0,
    parameter int LANE_H    = log_pkg::LANE_H
) (
    input  logic            CLK,
    input  logic            RESETn,
    log_move_ctrl_if.slave  bus
);
    localparam int IDX_W = idx_width(NUM_LOGS);
    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LOGS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    log_state_t       state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [CNT_W-1:0] frame_cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    coord_t           x_reg     [NUM_LOGS];
    speed_t           speed_reg [NUM_LOGS];
    logic             dir_reg   [NUM_LOGS];

    coord_t step_x;
    logic   cfg_ok;

    // Out-of-range config indices are silently dropped.
    assign cfg_ok = bus.cfg_we && ({1'b0, bus.cfg_idx} < (IDX_W+1)'(NUM_LOGS));

    log_pos_step #(.SCREEN_W(SCREEN_W)) u_step (
        .x   (x_reg[idx_reg]),
        .s   (speed_reg[idx_reg]),
        .dir (dir_reg[idx_reg]),
        .nx  (step_x)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            frame_cnt_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            for (int i = 0; i < NUM_LOGS; i++) begin
                x_reg[i]     <= coord_t'(i * (SCREEN_W / NUM_LOGS));
                speed_reg[i] <= speed_t'(1);
                dir_reg[i]   <= ((i % 2) == 0);
            end
        end else begin
            done_reg <= 1'b0;
            // The stepper reads the pre-edge speed/dir, so a colliding write only affects later sweeps.
            if (cfg_ok) begin
                speed_reg[bus.cfg_idx] <= bus.cfg_speed;
                dir_reg[bus.cfg_idx]   <= bus.cfg_dir;
            end
            case (state_reg)
                IDLE: begin
                    if (bus.startOfFrame && !bus.pause) begin
                        if (frame_cnt_reg == CNT_LAST) begin
                            frame_cnt_reg <= '0;
                            idx_reg       <= '0;
                            busy_reg      <= 1'b1;
                            state_reg     <= SWEEP;
                        end else begin
                            frame_cnt_reg <= frame_cnt_reg + 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    x_reg[idx_reg] <= step_x;
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LOGS; gi++) begin : g_log_out
            assign bus.ObjectStartX[gi] = x_reg[gi];
            assign bus.ObjectStartY[gi] = coord_t'(LANE_Y0 + gi * LANE_H);
        end
    endgenerate

    assign bus.busy        = busy_reg;
    assign bus.update_done = done_reg;

endmodule
